// File: rtl/atm_account_bank.sv
// atm_account_bank: account-side responder for the ATM controller.
//
// Keeps a register-based table of accounts (PIN, balance, consecutive failed-PIN count and
// lock flag) and serves one request at a time: IDLE accepts, EXEC updates the table and
// registers the response, RESP holds it until the consumer takes it.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cfg_we/cfg_acct/cfg_pin/
//   cfg_balance                     account provisioning (honoured in IDLE only)
//   req_valid/req_ready/req_op/
//   req_acct/req_pin/req_amount     request handshake and payload
//   rsp_valid/rsp_ready/
//   rsp_status/rsp_balance          registered response handshake and payload
module atm_account_bank #(
    parameter int unsigned NUM_ACCTS = 4,
    parameter int unsigned ACCT_W    = 2,
    parameter int unsigned BAL_W     = 8,
    parameter int unsigned PIN_W     = 4,
    parameter int unsigned MAX_TRIES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ACCT_W-1:0] cfg_acct,
    input  logic [PIN_W-1:0]  cfg_pin,
    input  logic [BAL_W-1:0]  cfg_balance,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ACCT_W-1:0] req_acct,
    input  logic [PIN_W-1:0]  req_pin,
    input  logic [BAL_W-1:0]  req_amount,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2:0]        rsp_status,
    output logic [BAL_W-1:0]  rsp_balance
);

    localparam int unsigned CNT_W = $clog2(MAX_TRIES + 1);

    localparam logic [2:0] OP_VERIFY  = 3'd0;
    localparam logic [2:0] OP_BALANCE = 3'd1;
    localparam logic [2:0] OP_WITHDRAW = 3'd2;
    localparam logic [2:0] OP_DEPOSIT = 3'd3;
    localparam logic [2:0] OP_CHG_PIN = 3'd4;
    localparam logic [2:0] OP_END     = 3'd5;

    localparam logic [2:0] ST_OK         = 3'd0;
    localparam logic [2:0] ST_BAD_PIN    = 3'd1;
    localparam logic [2:0] ST_LOCKED     = 3'd2;
    localparam logic [2:0] ST_NO_SESSION = 3'd3;
    localparam logic [2:0] ST_INSUFF     = 3'd4;
    localparam logic [2:0] ST_OVERFLOW   = 3'd5;
    localparam logic [2:0] ST_BAD_OP     = 3'd6;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    state_t state;

    logic [PIN_W-1:0] pin_tab  [NUM_ACCTS];
    logic [BAL_W-1:0] bal_tab  [NUM_ACCTS];
    logic [CNT_W-1:0] fail_tab [NUM_ACCTS];
    logic             lock_tab [NUM_ACCTS];

    logic              sess_open;
    logic [ACCT_W-1:0] sess_acct;

    logic [2:0]        op_q;
    logic [ACCT_W-1:0] acct_q;
    logic [PIN_W-1:0]  pin_q;
    logic [BAL_W-1:0]  amt_q;

    logic [BAL_W-1:0] cur_bal;
    logic             sess_hit;
    logic [BAL_W:0]   dep_sum;
    logic [CNT_W-1:0] fail_inc;

    assign req_ready = (state == StIdle) && !cfg_we && !rst;

    always_comb begin
        cur_bal  = bal_tab[acct_q];
        sess_hit = sess_open && (sess_acct == acct_q);
        // One extra bit so the carry out flags a deposit overflow.
        dep_sum  = {1'b0, cur_bal} + {1'b0, amt_q};
        fail_inc = fail_tab[acct_q] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            sess_open   <= 1'b0;
            sess_acct   <= '0;
            op_q        <= '0;
            acct_q      <= '0;
            pin_q       <= '0;
            amt_q       <= '0;
            rsp_valid   <= 1'b0;
            rsp_status  <= ST_OK;
            rsp_balance <= '0;
            for (int unsigned i = 0; i < NUM_ACCTS; i++) begin
                pin_tab[i]  <= '0;
                bal_tab[i]  <= '0;
                fail_tab[i] <= '0;
                lock_tab[i] <= 1'b0;
            end
        end else begin
            unique case (state)
                StIdle: begin
                    if (cfg_we) begin
                        pin_tab[cfg_acct]  <= cfg_pin;
                        bal_tab[cfg_acct]  <= cfg_balance;
                        fail_tab[cfg_acct] <= '0;
                        lock_tab[cfg_acct] <= 1'b0;
                        if (sess_open && (sess_acct == cfg_acct)) begin
                            sess_open <= 1'b0;
                        end
                    end else if (req_valid) begin
                        op_q   <= req_op;
                        acct_q <= req_acct;
                        pin_q  <= req_pin;
                        amt_q  <= req_amount;
                        state  <= StExec;
                    end
                end

                StExec: begin
                    state       <= StResp;
                    rsp_valid   <= 1'b1;
                    rsp_status  <= ST_OK;
                    rsp_balance <= '0;
                    if (op_q == OP_VERIFY) begin
                        sess_open <= 1'b0;
                        if (lock_tab[acct_q]) begin
                            rsp_status <= ST_LOCKED;
                        end else if (pin_tab[acct_q] == pin_q) begin
                            fail_tab[acct_q] <= '0;
                            sess_open        <= 1'b1;
                            sess_acct        <= acct_q;
                            rsp_balance      <= cur_bal;
                        end else begin
                            fail_tab[acct_q] <= fail_inc;
                            if (fail_inc == CNT_W'(MAX_TRIES)) begin
                                lock_tab[acct_q] <= 1'b1;
                                rsp_status       <= ST_LOCKED;
                            end else begin
                                rsp_status <= ST_BAD_PIN;
                            end
                        end
                    end else if (op_q > OP_END) begin
                        rsp_status <= ST_BAD_OP;
                    end else if (!sess_hit) begin
                        rsp_status <= ST_NO_SESSION;
                    end else begin
                        rsp_balance <= cur_bal;
                        case (op_q)
                            OP_WITHDRAW: begin
                                if (amt_q > cur_bal) begin
                                    rsp_status <= ST_INSUFF;
                                end else begin
                                    bal_tab[acct_q] <= cur_bal - amt_q;
                                    rsp_balance     <= cur_bal - amt_q;
                                end
                            end
                            OP_DEPOSIT: begin
                                if (dep_sum[BAL_W]) begin
                                    rsp_status <= ST_OVERFLOW;
                                end else begin
                                    bal_tab[acct_q] <= dep_sum[BAL_W-1:0];
                                    rsp_balance     <= dep_sum[BAL_W-1:0];
                                end
                            end
                            OP_CHG_PIN: pin_tab[acct_q] <= amt_q[PIN_W-1:0];
                            OP_END:     sess_open <= 1'b0;
                            default:    ; // OP_BALANCE: nothing to update
                        endcase
                    end
                end

                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule
